// File: rtl/sfifo_if.sv
// sfifo_if: groups the producer write port, consumer pop port and status of sfifo.
// Latency: none (wires only).
// Backpressure: full_o (and afull_o when SFIFO_AFULL_EN is defined) tell the producer to stop.
//
// Signals (directions seen from the FIFO, i.e. the slave modport):
//   wr_i, din_i         in   producer write request / data
//   rd_i                in   consumer pop strobe
//   flag_clr_i          in   clear sticky ovf_o/udf_o
//   dout_o              out  head word (first-word-fall-through), 0 when empty
//   empty_o, full_o     out  occupancy decodes
//   level_o             out  entry count 0..2**AW
//   ovf_o, udf_o        out  sticky overflow / underflow
//   afull_o             out  almost-full, only with SFIFO_AFULL_EN
interface sfifo_if #(
    parameter int DW = 16,
    parameter int AW = 4
);
    logic          wr_i;
    logic [DW-1:0] din_i;
    logic          rd_i;
    logic          flag_clr_i;
    logic [DW-1:0] dout_o;
    logic          empty_o;
    logic          full_o;
    logic [AW:0]   level_o;
    logic          ovf_o;
    logic          udf_o;
`ifdef SFIFO_AFULL_EN
    logic          afull_o;
`endif

    // FIFO side
    modport slave (
        input  wr_i,
        input  din_i,
        input  rd_i,
        input  flag_clr_i,
        output dout_o,
        output empty_o,
        output full_o,
        output level_o,
        output ovf_o,
`ifdef SFIFO_AFULL_EN
        output afull_o,
`endif
        output udf_o
    );

    // Producer / consumer side
    modport master (
        output wr_i,
        output din_i,
        output rd_i,
        output flag_clr_i,
        input  dout_o,
        input  empty_o,
        input  full_o,
        input  level_o,
        input  ovf_o,
`ifdef SFIFO_AFULL_EN
        input  afull_o,
`endif
        input  udf_o
    );
endinterface

// File: rtl/sfifo.sv
// sfifo: single-clock first-word-fall-through FIFO for 16-bit motion/IO command words.
// Latency: a write at edge N is visible on dout_o after edge N; a pop advances the head on its edge.
// Backpressure: writes into a full FIFO are dropped (sticky ovf_o) unless a pop happens on that same edge.
//
// Ports:
//   wb_clk_i   in   system clock, rising edge
//   wb_rst_i   in   synchronous active-high reset, priority over all other inputs
//   bus        sfifo_if.slave: wr_i/din_i, rd_i, flag_clr_i in;
//              dout_o, empty_o, full_o, level_o, ovf_o, udf_o (afull_o) out
// Build option: define SFIFO_AFULL_EN to add the registered afull_o flag (level >= AFULL_LVL).
module sfifo #(
    parameter int DW        = 16,
    parameter int AW        = 4,
    parameter int AFULL_LVL = 12
) (
    input  logic    wb_clk_i,
    input  logic    wb_rst_i,
    sfifo_if.slave  bus
);

    localparam int          DEPTH    = 1 << AW;
    localparam logic [AW:0] LVL_FULL = (AW + 1)'(DEPTH);

    // An almost-full threshold beyond the depth could never assert.
    if (AFULL_LVL > DEPTH || AFULL_LVL < 1) begin : g_afull_lvl_chk
        $error("sfifo: AFULL_LVL must lie in 1..2**AW");
    end

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [DW-1:0] r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [AW:0]   r_level;
    logic          r_ovf;
    logic          r_udf;

    logic          w_full;
    logic          w_empty;
    logic          w_wr_acc;
    logic          w_rd_acc;
    logic          w_ovf_set;
    logic          w_udf_set;
    logic [AW:0]   w_level_nxt;

    // ------------------------------------------------------------------
    // Accept decisions, all from pre-edge state
    // ------------------------------------------------------------------
    assign w_full    = (r_level == LVL_FULL);
    assign w_empty   = (r_level == '0);

    // A pop on the same edge frees the slot, so a full FIFO still takes the write.
    assign w_wr_acc  = bus.wr_i & (~w_full | bus.rd_i);
    // An empty FIFO cannot pop, even if a write lands on the same edge.
    assign w_rd_acc  = bus.rd_i & ~w_empty;

    assign w_ovf_set = bus.wr_i & w_full & ~bus.rd_i;
    assign w_udf_set = bus.rd_i & w_empty;

    always_comb begin
        w_level_nxt = r_level;
        case ({w_wr_acc, w_rd_acc})
            2'b10:   w_level_nxt = r_level + 1'b1;
            2'b01:   w_level_nxt = r_level - 1'b1;
            default: w_level_nxt = r_level;
        endcase
    end

    // ------------------------------------------------------------------
    // Storage: not cleared by reset, but a write presented with reset is dropped.
    // ------------------------------------------------------------------
    always_ff @(posedge wb_clk_i) begin
        if (!wb_rst_i && w_wr_acc) begin
            r_mem[r_wr_ptr] <= bus.din_i;
        end
    end

    // ------------------------------------------------------------------
    // Pointers and level; pointers wrap naturally at 2**AW.
    // ------------------------------------------------------------------
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_wr_acc) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_rd_acc) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            r_level <= w_level_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Sticky error flags: a set event in the clear cycle wins over the clear.
    // ------------------------------------------------------------------
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            r_ovf <= 1'b0;
            r_udf <= 1'b0;
        end else begin
            r_ovf <= w_ovf_set | (r_ovf & ~bus.flag_clr_i);
            r_udf <= w_udf_set | (r_udf & ~bus.flag_clr_i);
        end
    end

`ifdef SFIFO_AFULL_EN
    // ------------------------------------------------------------------
    // Almost-full: registered from the post-update level so it moves on the
    // same edge as level_o.
    // ------------------------------------------------------------------
    localparam logic [AW:0] LVL_AFULL = (AW + 1)'(AFULL_LVL);
    logic r_afull;

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            r_afull <= 1'b0;
        end else begin
            r_afull <= (w_level_nxt >= LVL_AFULL);
        end
    end

    assign bus.afull_o = r_afull;
`endif

    // ------------------------------------------------------------------
    // Outputs. The head word is a combinational read so the consumer can
    // latch it on the edge that pops it; stale array contents are masked
    // while empty.
    // ------------------------------------------------------------------
    assign bus.dout_o  = w_empty ? '0 : r_mem[r_rd_ptr];
    assign bus.empty_o = w_empty;
    assign bus.full_o  = w_full;
    assign bus.level_o = r_level;
    assign bus.ovf_o   = r_ovf;
    assign bus.udf_o   = r_udf;

endmodule
